// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer for the fetch stage. Sequential
//                advance by STEP, jump / taken-branch / call redirects to
//                'target', return via an internal circular return-address
//                stack (RAS), a pipeline stall, and sticky RAS overflow /
//                underflow flags. All outputs are registered.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1    rising-edge clock
//    rst            in   1    asynchronous active-high reset
//    stall          in   1    freeze pc, RAS, count and flags this cycle
//    ctrl           in   1    sequential advance enable (pc += STEP)
//    is_jump        in   1    unconditional redirect to target
//    is_branch      in   1    conditional redirect, taken when equal=1
//    equal          in   1    branch comparator result
//    is_call        in   1    redirect to target, push pc+STEP
//    is_ret         in   1    redirect to RAS top and pop
//    target         in   AW   redirect address
//    pc             out  AW   current program counter
//    ras_count      out  CW   number of valid RAS entries (0..RAS_DEPTH)
//    ras_overflow   out  1    sticky: call while RAS full
//    ras_underflow  out  1    sticky: return while RAS empty
// ============================================================================
module pc_sequencer #(
    parameter int AW        = 8,
    parameter int STEP      = 4,
    parameter int RESET_PC  = 0,
    parameter int RAS_DEPTH = 4,
    localparam int CW       = $clog2(RAS_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          ctrl,
    input  logic          is_jump,
    input  logic          is_branch,
    input  logic          equal,
    input  logic          is_call,
    input  logic          is_ret,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc,
    output logic [CW-1:0] ras_count,
    output logic          ras_overflow,
    output logic          ras_underflow
);

    // RAS_DEPTH is a power of two, so the pointer wraps naturally at its width.
    localparam int            c_PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [AW-1:0] c_STEP     = AW'(STEP);
    localparam logic [AW-1:0] c_RESET_PC = AW'(RESET_PC);
    // Pointer starts one below slot 0 so the first push lands at index 0.
    localparam logic [c_PTR_W-1:0] c_TOP_INIT = c_PTR_W'(RAS_DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [CW-1:0]      c_FULL     = CW'(RAS_DEPTH);
    localparam logic [CW-1:0]      c_CNT_ONE  = CW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]      r_pc;
    logic [c_PTR_W-1:0] r_top;
    logic [CW-1:0]      r_count;
    logic               r_ovf;
    logic               r_unf;
    logic [AW-1:0]      r_ras [RAS_DEPTH];

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [AW-1:0]      w_pc_inc;
    logic [c_PTR_W-1:0] w_top_inc;
    logic [c_PTR_W-1:0] w_top_dec;
    logic [AW-1:0]      w_ras_top;
    logic [AW-1:0]      w_pc_nxt;
    logic [c_PTR_W-1:0] w_top_nxt;
    logic [CW-1:0]      w_count_nxt;
    logic               w_ovf_nxt;
    logic               w_unf_nxt;
    logic               w_push;

    always_comb begin
        // pc+STEP wraps modulo 2^AW by construction of the AW-bit sum.
        w_pc_inc    = r_pc + c_STEP;
        w_top_inc   = r_top + c_PTR_ONE;
        w_top_dec   = r_top - c_PTR_ONE;
        w_ras_top   = r_ras[r_top];

        w_pc_nxt    = r_pc;
        w_top_nxt   = r_top;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_push      = 1'b0;

        if (!stall) begin
            if (is_ret) begin
                // Return wins over a simultaneous call; the call is dropped.
                if (r_count != '0) begin
                    w_pc_nxt    = w_ras_top;
                    w_top_nxt   = w_top_dec;
                    w_count_nxt = r_count - c_CNT_ONE;
                end else begin
                    // Empty stack: flag it and carry on sequentially.
                    w_unf_nxt   = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                end
            end else if (is_call) begin
                w_pc_nxt  = target;
                w_push    = 1'b1;
                w_top_nxt = w_top_inc;
                // When full the push overwrites the oldest slot, count stays.
                if (r_count == c_FULL) begin
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_count_nxt = r_count + c_CNT_ONE;
                end
            end else if (is_jump || (is_branch && equal)) begin
                w_pc_nxt = target;
            end else if (ctrl) begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers (asynchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= c_RESET_PC;
            r_top   <= c_TOP_INIT;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_top   <= w_top_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // RAS storage. Contents are meaningless until pushed, so no reset.
    // Written at the edge, which lets a ret in the next cycle read the
    // just-pushed address without any bypass.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_top_inc] <= w_pc_inc;
        end
    end

    assign pc            = r_pc;
    assign ras_count     = r_count;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. Directed scenarios
//                compared against hand-derived constants, then randomized
//                traffic compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int AW        = 8;
    localparam int STEP      = 4;
    localparam int RESET_PC  = 0;
    localparam int RAS_DEPTH = 4;
    localparam int CW        = $clog2(RAS_DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          stall, ctrl, is_jump, is_branch, equal, is_call, is_ret;
    logic [AW-1:0] target;
    logic [AW-1:0] pc;
    logic [CW-1:0] ras_count;
    logic          ras_overflow, ras_underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: a bounded stack held as a queue (oldest at front).
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_q[$];
    logic          m_ovf, m_unf;

    pc_sequencer #(
        .AW(AW), .STEP(STEP), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .ctrl(ctrl),
        .is_jump(is_jump), .is_branch(is_branch), .equal(equal),
        .is_call(is_call), .is_ret(is_ret), .target(target),
        .pc(pc), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_pc  = AW'(RESET_PC);
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic idle_inputs();
        stall = 0; ctrl = 0; is_jump = 0; is_branch = 0; equal = 0;
        is_call = 0; is_ret = 0; target = '0;
    endtask

    // One clock: drive at negedge, update model at posedge, settle 1 unit.
    task automatic cycle(input bit st, input bit c, input bit j, input bit b,
                         input bit e, input bit ca, input bit r,
                         input logic [AW-1:0] t);
        @(negedge clk);
        stall = st; ctrl = c; is_jump = j; is_branch = b; equal = e;
        is_call = ca; is_ret = r; target = t;
        @(posedge clk);
        if (!st) begin
            if (r) begin
                if (m_q.size() > 0) m_pc = m_q.pop_back();
                else begin m_unf = 1'b1; m_pc = m_pc + AW'(STEP); end
            end else if (ca) begin
                if (m_q.size() == RAS_DEPTH) begin
                    void'(m_q.pop_front());
                    m_ovf = 1'b1;
                end
                m_q.push_back(m_pc + AW'(STEP));
                m_pc = t;
            end else if (j || (b && e)) begin
                m_pc = t;
            end else if (c) begin
                m_pc = m_pc + AW'(STEP);
            end
        end
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle (between negedge and posedge).
    task automatic assert_reset_mid();
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        #1 rst = 1'b0;
    endtask

    task automatic fresh_start();
        assert_reset_mid();
        release_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (pc !== 8'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (ras_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
        checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            failures++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0/0", ras_overflow, ras_underflow); end
        // Hold reset across an edge with ctrl=1: pc must stay at reset value.
        @(negedge clk); ctrl = 1'b1;
        @(posedge clk); #1;
        checks++; if (pc !== 8'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", pc); end
        @(negedge clk); ctrl = 1'b0;
        release_reset();
    endtask

    task automatic test_advance();
        logic [AW-1:0] exp_seq[3];
        exp_seq[0] = 8'd4; exp_seq[1] = 8'd8; exp_seq[2] = 8'd12;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 0, 8'd0);
            checks++; if (pc !== exp_seq[i]) begin failures++; $display("FAIL advance_%0d got=%0d exp=%0d", i, pc, exp_seq[i]); end
        end
        cycle(0, 0, 1, 0, 0, 0, 0, 8'd252);
        checks++; if (pc !== 8'd252) begin failures++; $display("FAIL jump_252 got=%0d exp=252", pc); end
        cycle(0, 1, 0, 0, 0, 0, 0, 8'd0);
        checks++; if (pc !== 8'd0) begin failures++; $display("FAIL wrap got=%0d exp=0", pc); end
        // Mid-run async reset from a non-reset pc
        cycle(0, 0, 1, 0, 0, 0, 0, 8'd96);
        assert_reset_mid();
        checks++; if (pc !== 8'd0) begin failures++; $display("FAIL async_reset got=%0d exp=0", pc); end
        release_reset();
    endtask

    task automatic test_priority();
        cycle(0, 0, 1, 0, 0, 0, 0, 8'd8);
        cycle(0, 0, 1, 1, 0, 0, 0, 8'd40);
        checks++; if (pc !== 8'd40) begin failures++; $display("FAIL prio_jump got=%0d exp=40", pc); end
        cycle(0, 0, 0, 1, 0, 0, 0, 8'd90);
        checks++; if (pc !== 8'd40) begin failures++; $display("FAIL branch_not_taken_hold got=%0d exp=40", pc); end
        cycle(1, 1, 1, 0, 0, 0, 0, 8'd77);
        checks++; if (pc !== 8'd40) begin failures++; $display("FAIL stall_jump got=%0d exp=40", pc); end
        cycle(0, 1, 0, 1, 0, 0, 0, 8'd90);
        checks++; if (pc !== 8'd44) begin failures++; $display("FAIL branch_nt_ctrl got=%0d exp=44", pc); end
        cycle(0, 1, 0, 1, 1, 0, 0, 8'd200);
        checks++; if (pc !== 8'd200) begin failures++; $display("FAIL branch_taken got=%0d exp=200", pc); end
        cycle(1, 0, 0, 0, 0, 1, 0, 8'd10);
        checks++; if (pc !== 8'd200 || ras_count !== '0) begin
            failures++; $display("FAIL stall_call got pc=%0d cnt=%0d exp pc=200 cnt=0", pc, ras_count); end
    endtask

    task automatic test_call_return();
        fresh_start();
        cycle(0, 0, 1, 0, 0, 0, 0, 8'd16);
        cycle(0, 0, 0, 0, 0, 1, 0, 8'd100);
        checks++; if (pc !== 8'd100 || ras_count !== CW'(1)) begin
            failures++; $display("FAIL call got pc=%0d cnt=%0d exp pc=100 cnt=1", pc, ras_count); end
        cycle(0, 1, 0, 0, 0, 0, 0, 8'd0);
        cycle(0, 1, 0, 0, 0, 0, 0, 8'd0);
        checks++; if (pc !== 8'd108) begin failures++; $display("FAIL call_body got=%0d exp=108", pc); end
        cycle(0, 0, 0, 0, 0, 0, 1, 8'd0);
        checks++; if (pc !== 8'd20 || ras_count !== '0) begin
            failures++; $display("FAIL ret got pc=%0d cnt=%0d exp pc=20 cnt=0", pc, ras_count); end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_ret[4];
        exp_ret[0] = 8'd20; exp_ret[1] = 8'd16; exp_ret[2] = 8'd12; exp_ret[3] = 8'd8;
        fresh_start();
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, 0, AW'((i + 1) * 4));
        checks++; if (ras_count !== CW'(4) || ras_overflow !== 1'b1 || pc !== 8'd20) begin
            failures++; $display("FAIL overflow got cnt=%0d ovf=%b pc=%0d exp cnt=4 ovf=1 pc=20", ras_count, ras_overflow, pc); end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 1, 8'd0);
            checks++; if (pc !== exp_ret[i]) begin failures++; $display("FAIL ovf_ret_%0d got=%0d exp=%0d", i, pc, exp_ret[i]); end
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 8'd0);
        checks++; if (ras_underflow !== 1'b1 || pc !== 8'd12 || ras_count !== '0) begin
            failures++; $display("FAIL underflow got unf=%b pc=%0d cnt=%0d exp unf=1 pc=12 cnt=0", ras_underflow, pc, ras_count); end
    endtask

    task automatic test_back_to_back();
        fresh_start();
        cycle(0, 0, 1, 0, 0, 0, 0, 8'd40);
        cycle(0, 0, 0, 0, 0, 1, 0, 8'd60);
        cycle(0, 0, 0, 0, 0, 1, 1, 8'd100);
        checks++; if (pc !== 8'd44 || ras_count !== '0 || ras_overflow !== 1'b0) begin
            failures++; $display("FAIL call_ret got pc=%0d cnt=%0d ovf=%b exp pc=44 cnt=0 ovf=0", pc, ras_count, ras_overflow); end
        cycle(0, 0, 0, 0, 0, 0, 1, 8'd0);
        checks++; if (ras_underflow !== 1'b1 || pc !== 8'd48) begin
            failures++; $display("FAIL no_push got unf=%b pc=%0d exp unf=1 pc=48", ras_underflow, pc); end
    endtask

    task automatic test_reset_mid_stack();
        fresh_start();
        cycle(0, 0, 0, 0, 0, 1, 0, 8'd32);
        cycle(0, 0, 0, 0, 0, 1, 0, 8'd64);
        checks++; if (ras_count !== CW'(2)) begin failures++; $display("FAIL two_calls got=%0d exp=2", ras_count); end
        assert_reset_mid();
        checks++; if (pc !== 8'd0 || ras_count !== '0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            failures++; $display("FAIL mid_stack_reset got pc=%0d cnt=%0d ovf=%b unf=%b exp 0/0/0/0", pc, ras_count, ras_overflow, ras_underflow); end
        release_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 8'd0);
        checks++; if (ras_underflow !== 1'b1 || pc !== 8'd4) begin
            failures++; $display("FAIL ret_after_reset got unf=%b pc=%0d exp unf=1 pc=4", ras_underflow, pc); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        fresh_start();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                fresh_start();
            end
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, AW'($urandom));
            checks++;
            if (pc !== m_pc || ras_count !== CW'(m_q.size()) ||
                ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d got pc=%0d cnt=%0d ovf=%b unf=%b exp pc=%0d cnt=%0d ovf=%b unf=%b",
                             i, pc, ras_count, ras_overflow, ras_underflow,
                             m_pc, m_q.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        test_reset();
        test_advance();
        test_priority();
        test_call_return();
        test_overflow();
        test_back_to_back();
        test_reset_mid_stack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the FullCPU fetch stage, generalising the fixed 5-bit counter to configurable width, step and reset vector. It adds a pipeline stall and call/return support through an internal circular return-address stack (RAS), with occupancy and sticky error flags. Its output drives the instruction-memory address; jump, branch, call and return decisions come from the decoder and comparator in the same cycle.

## Interface
- AW, 8, PC and target width in bits (≥3)
- STEP, 4, increment added on sequential advance and to form the return address
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)
- CW (local), $clog2(RAS_DEPTH+1), width of ras_count
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freezes PC, RAS and flags for the cycle
- ctrl  in  1  sequential advance enable
- is_jump  in  1  unconditional redirect to target
- is_branch  in  1  conditional redirect; taken when equal=1
- equal  in  1  branch comparator result
- is_call  in  1  redirect to target and push PC+STEP
- is_ret  in  1  redirect to top of RAS and pop
- target  in  AW  redirect address
- pc  out  AW  current program counter
- ras_count  out  CW  valid RAS entries, 0..RAS_DEPTH
- ras_overflow  out  1  sticky: a call was made while RAS full
- ras_underflow  out  1  sticky: a return was made while RAS empty

## Operation
- All state updates occur on the clk rising edge. Priority per cycle: rst > stall > is_ret > is_call > is_jump > taken branch > ctrl > hold.
- stall=1: pc, RAS contents, ras_count and flags all hold, regardless of any other input.
- is_ret, ras_count>0: pc <= RAS[top]; top decrements modulo RAS_DEPTH; ras_count decrements.
- is_ret, ras_count=0: ras_underflow <= 1; pc <= pc+STEP; RAS unchanged.
- is_call (is_ret=0): pc <= target; RAS[top+1] <= pc+STEP; top increments modulo RAS_DEPTH; ras_count saturates at RAS_DEPTH.
- is_call with ras_count=RAS_DEPTH: the write overwrites the oldest entry (circular); ras_overflow <= 1.
- is_call and is_ret together: only the return is performed; the call is ignored entirely.
- is_jump: pc <= target. is_branch && equal: pc <= target. is_branch && !equal: falls through to the ctrl rule.
- Redirects (ret, call, jump, taken branch) do not require ctrl=1.
- ctrl=1 with no redirect: pc <= pc+STEP. Otherwise pc holds.
- Arithmetic: pc+STEP is computed modulo 2^AW, so it wraps silently. target is used as-is at AW bits.
- Sticky flags clear only on rst.

## Timing
- Reset (asynchronous, immediate): pc=RESET_PC, ras_count=0, top pointer=RAS_DEPTH-1 so the first push lands at index 0, ras_overflow=0, ras_underflow=0. RAS data contents are don't-care.
- rst deasserted mid-operation: all history is discarded and the first valid edge follows the reset values above.
- Latency: one cycle. Inputs sampled at edge N take effect on pc after edge N. All outputs are registered, with no combinational path from inputs to outputs.
- The return address pushed is the pc value registered before the edge, plus STEP.
- A ret in the cycle after a call returns the address just pushed (pc_at_call+STEP). This is the back-to-back case and requires no bypass, since RAS is written at the edge.

## Test plan
Default parameters (AW=8, STEP=4, RESET_PC=0, RAS_DEPTH=4) unless noted.
- Reset and advance: rst pulse mid-cycle -> pc=0 immediately. ctrl=1 for 3 cycles -> pc 4, 8, 12. From pc=252, ctrl=1 -> pc=0 (wrap).
- Priority: from pc=8, is_jump=1, target=40, and is_branch=1, equal=0, same cycle -> pc=40. Next cycle, is_branch=1, equal=0, ctrl=0 -> pc=40 holds. Then stall=1 with is_jump=1 -> pc unchanged.
- Call/return: at pc=16, is_call with target=100 -> pc=100, ras_count=1. ctrl for 2 cycles -> pc=108. is_ret -> pc=20, ras_count=0.
- Overflow: 5 nested calls from pc=0, 4, 8, 12, 16 (each call targets the next) -> ras_count=4, ras_overflow=1. Then 4 rets -> pc 20, 16, 12, 8. A 5th ret -> ras_underflow=1, pc=12.
- Simultaneous call+ret: with RAS holding 44, assert both -> pc=44, ras_count decrements, nothing pushed.
- Reset mid-stack: 2 calls, then rst -> ras_count=0, flags 0, pc=0. A following ret -> ras_underflow=1, pc=4.
